// File: rtl/marquee_scroller.sv
// marquee_scroller: N-digit 16-segment scrolling marquee engine.
// An ASCII message held in an internal buffer is scrolled left across
// NUM_DIGITS time-multiplexed digits. Segment outputs are active-low,
// digit selects are one-hot active-high with bit 0 the leftmost digit.
// Optional feature macro: LOWERCASE_FOLD_EN (fold 'a'..'z' onto 'A'..'Z').
module marquee_scroller #(
    parameter int NUM_DIGITS = 4,
    parameter int MSG_DEPTH  = 32,
    parameter int MUX_DIV    = 1000,
    parameter int SCROLL_DIV = 5000000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [$clog2(MSG_DEPTH)-1:0]   wr_addr,
    input  logic [7:0]                     wr_data,
    input  logic                           len_wr,
    input  logic [$clog2(MSG_DEPTH):0]     len_data,
    input  logic                           pause,
    output logic [15:0]                    segments,
    output logic [NUM_DIGITS-1:0]          digit_sel,
    output logic                           scroll_wrap
);
    localparam int AW = $clog2(MSG_DEPTH);
    localparam int LW = AW + 1;
    localparam int MW = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
    localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [MW-1:0]         MUX_LAST    = MW'(MUX_DIV - 1);
    localparam logic [SW-1:0]         SCROLL_LAST = SW'(SCROLL_DIV - 1);
    localparam logic [DW-1:0]         DIG_LAST    = DW'(NUM_DIGITS - 1);
    localparam logic [LW-1:0]         LEN_MAX     = LW'(MSG_DEPTH);
    localparam logic [NUM_DIGITS-1:0] SEL_ONE     = NUM_DIGITS'(1);

    // Character glyph lookup; anything without a glyph is blank.
    function automatic logic [15:0] decode(input logic [7:0] c);
        logic [7:0] u;
        u = c;
`ifdef LOWERCASE_FOLD_EN
        if ((c >= 8'h61) && (c <= 8'h7A)) begin
            u = c - 8'h20;
        end else begin
            u = c;
        end
`endif
        case (u)
            8'h30: decode = 16'h00FF;  8'h31: decode = 16'hCFF7;
            8'h32: decode = 16'h113F;  8'h33: decode = 16'h03BF;
            8'h34: decode = 16'hCE3F;  8'h35: decode = 16'h223F;
            8'h36: decode = 16'h203F;  8'h37: decode = 16'h0FFF;
            8'h38: decode = 16'h003F;  8'h39: decode = 16'h023F;
            8'h3D: decode = 16'hF33F;  8'h41: decode = 16'h0C3F;
            8'h42: decode = 16'h03AD;  8'h43: decode = 16'h30FF;
            8'h44: decode = 16'h03ED;  8'h45: decode = 16'h303F;
            8'h46: decode = 16'h3C7F;  8'h47: decode = 16'h20BF;
            8'h48: decode = 16'hCC3F;  8'h49: decode = 16'h33ED;
            8'h4A: decode = 16'hC1FF;  8'h4B: decode = 16'hFC73;
            8'h4C: decode = 16'hF0FF;  8'h4D: decode = 16'hCCD7;
            8'h4E: decode = 16'hCCDB;  8'h4F: decode = 16'h00FF;
            8'h50: decode = 16'h1C3F;  8'h51: decode = 16'h00FB;
            8'h52: decode = 16'h1C3B;  8'h53: decode = 16'h223F;
            8'h54: decode = 16'h3FED;  8'h55: decode = 16'hC0FF;
            8'h56: decode = 16'hFCF6;  8'h57: decode = 16'hCCFA;
            8'h58: decode = 16'hFFD2;  8'h59: decode = 16'hFFD5;
            8'h5A: decode = 16'h33F6;  8'h5F: decode = 16'hF3FF;
            default: decode = 16'hFFFF;
        endcase
    endfunction

    logic [7:0]            mem [MSG_DEPTH];
    logic [LW-1:0]         msg_len;
    logic [AW-1:0]         offset;
    logic [SW-1:0]         scroll_cnt;
    logic [MW-1:0]         mux_cnt;
    logic [DW-1:0]         scan_idx;
    logic [AW-1:0]         ptr;
    logic [7:0]            rd_char;
    logic                  valid_p1;
    logic                  blank_p1;
    logic [DW-1:0]         sel_p1;
    logic [LW-1:0]         off_inc;
    logic [LW-1:0]         ptr_inc;

    assign off_inc = {1'b0, offset} + LW'(1);
    assign ptr_inc = {1'b0, ptr} + LW'(1);

    // Message buffer: synchronous write, registered read of the current pointer.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_char <= mem[ptr];
    end

    // Length load and scroll divider; a length load overrides a same-cycle tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msg_len     <= '0;
            offset      <= '0;
            scroll_cnt  <= '0;
            scroll_wrap <= 1'b0;
        end else begin
            scroll_wrap <= 1'b0;
            if (len_wr) begin
                msg_len    <= (len_data > LEN_MAX) ? LEN_MAX : len_data;
                offset     <= '0;
                scroll_cnt <= '0;
            end else if (!pause) begin
                if (scroll_cnt == SCROLL_LAST) begin
                    scroll_cnt <= '0;
                    if (msg_len != '0) begin
                        if (off_inc == msg_len) begin
                            offset      <= '0;
                            scroll_wrap <= 1'b1;
                        end else begin
                            offset <= offset + AW'(1);
                        end
                    end
                end else begin
                    scroll_cnt <= scroll_cnt + SW'(1);
                end
            end
        end
    end

    // Free-running digit scan; the pointer restarts at the offset on digit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mux_cnt  <= '0;
            scan_idx <= '0;
            ptr      <= '0;
        end else if (mux_cnt == MUX_LAST) begin
            mux_cnt <= '0;
            if (scan_idx == DIG_LAST) begin
                scan_idx <= '0;
                ptr      <= offset;
            end else begin
                scan_idx <= scan_idx + DW'(1);
                ptr      <= (ptr_inc >= msg_len) ? '0 : ptr + AW'(1);
            end
        end else begin
            mux_cnt <= mux_cnt + MW'(1);
        end
    end

    // Two-stage output pipeline keeping digit_sel aligned with its segments.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_p1  <= 1'b0;
            blank_p1  <= 1'b1;
            sel_p1    <= '0;
            segments  <= 16'hFFFF;
            digit_sel <= '0;
        end else begin
            valid_p1  <= 1'b1;
            blank_p1  <= (msg_len == '0);
            sel_p1    <= scan_idx;
            segments  <= (!valid_p1 || blank_p1) ? 16'hFFFF : decode(rd_char);
            digit_sel <= valid_p1 ? (SEL_ONE << sel_p1) : '0;
        end
    end
endmodule

// File: doc/marquee_scroller.md
Name: marquee_scroller

Overview:
- Parametrised N-digit 16-segment scrolling marquee engine.
- Holds an ASCII message in an internal buffer and scrolls it left across NUM_DIGITS time-multiplexed displays.
- Decodes each character to active-low segments and drives one-hot digit selects.
- Sits between the host/UART message writer and the display pin drivers.

Parameters:
- NUM_DIGITS, 4: number of physical 16-segment digits, 1..16.
- MSG_DEPTH, 32: message buffer depth in characters, power of 2, at least 2.
- MUX_DIV, 1000: clk cycles each digit stays selected, at least 4.
- SCROLL_DIV, 5000000: clk cycles per one-character scroll step, at least 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- wr_en  in  1  write wr_data into the buffer at wr_addr.
- wr_addr  in  log2(MSG_DEPTH)  buffer write address.
- wr_data  in  8  ASCII character.
- len_wr  in  1  load the message length.
- len_data  in  log2(MSG_DEPTH)+1  new message length, 0..MSG_DEPTH.
- pause  in  1  freeze scroll position while high.
- segments  out  16  active-low segment pattern, bit15..0 = a1 a2 b c d1 d2 e f g1 g2 h i j k l m.
- digit_sel  out  NUM_DIGITS  one-hot active-high digit enable; bit 0 is the leftmost digit.
- scroll_wrap  out  1  one-cycle pulse when the scroll offset wraps to 0.

Behaviour:
- Reset (asynchronous, active-high): segments=16'hFFFF, digit_sel=0, scroll_wrap=0, offset=0, msg_len=0, all dividers and the scan index at 0. Buffer contents are not reset.
- Buffer: synchronous write, 1-cycle synchronous read. A write lands in the next cycle; a displayed slot shows new data from its next fetch onward.
- len_wr:
  - msg_len is loaded from len_data, clamped to MSG_DEPTH if larger.
  - offset is cleared to 0 and the scroll divider is cleared.
  - len_wr wins over a scroll tick in the same cycle.
- Scroll divider:
  - Counts 0..SCROLL_DIV-1 and ticks at terminal count. pause holds the divider.
  - On a tick with msg_len>0: offset becomes offset+1. When offset+1==msg_len, offset becomes 0 and scroll_wrap pulses in the following cycle.
  - msg_len==1 wraps on every tick.
- Scan divider:
  - Counts 0..MUX_DIV-1. At terminal count the scan index d advances 0..NUM_DIGITS-1 and wraps to 0.
  - Scanning never stops; pause does not affect it.
- Character pointer (no divider):
  - At d=0, ptr=offset.
  - Each subsequent digit: ptr = (ptr+1==msg_len) ? 0 : ptr+1.
  - If NUM_DIGITS > msg_len, the message repeats across the display.
  - Offset changes take effect at the next d=0.
- Pipeline:
  - Scan advance, then buffer read (1 cycle), then decode register (1 cycle).
  - segments and digit_sel update together, exactly 2 cycles after the scan advance. digit_sel is delayed to match.
- Decode:
  - ASCII 0x30..0x60 uses the team's standard 16-segment font, active-low.
  - Required codes: '0'=16'h00FF, '1'=16'hCFF7, '8'=16'h003F, 'A'=16'h0C3F, 'E'=16'h303F, ' '=16'hFFFF.
  - All other codes give 16'hFFFF.
- msg_len==0: segments=16'hFFFF for every digit; digit_sel keeps scanning; no scroll_wrap pulses.
- Reset mid-operation: outputs go to reset values immediately, without waiting for clk.

Optional Feature:
- LOWERCASE_FOLD_EN defined: ASCII 0x61..0x7A are decoded as the matching uppercase glyph ('a' gives the same pattern as 'A', 16'h0C3F).
- Undefined: 0x61..0x7A decode to blank (16'hFFFF).
- No port changes either way.

Test Plan:
- NUM_DIGITS=4, MUX_DIV=4, SCROLL_DIV=64, release reset -> segments=16'hFFFF, digit_sel=0 during reset; after release digit_sel cycles 0001,0010,0100,1000, each held 4 clk, with segments=16'hFFFF.
- Write "18AE" to addr 0..3, len=4 -> digits 0..3 show 16'hCFF7, 16'h003F, 16'h0C3F, 16'h303F. The first segments/digit_sel change is 2 clk after the scan advance.
- Same message, wait one scroll tick -> digits show '8','A','E','1'. After 4 ticks offset=0, with a single-cycle scroll_wrap pulse.
- len=2 with "10" -> display reads "1010", rotating to "0101" after one tick; scroll_wrap pulses every 2 ticks.
- Hold pause for 200 clk -> display content frozen while digit_sel keeps scanning. len_wr issued on the same cycle as a scroll tick -> offset=0 and no scroll_wrap pulse.
- Write 'a' (0x61) -> with LOWERCASE_FOLD_EN defined shows 16'h0C3F, without it shows 16'hFFFF. Assert rst mid-scan -> all outputs at reset values within the same cycle.
